// File: rtl/tpu_pkg.sv
// Shared TPU sequencing types and constants: FSM state encoding, opcodes and stream length.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    SETTLE = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [2:0] OPC_NOP    = 3'b000;
  localparam logic [2:0] OPC_LOAD_W = 3'b001;

  localparam int unsigned STREAM_STEPS = 3;
  localparam int unsigned STEP_W       = 2;

endpackage

// File: rtl/matmul_sequencer_operand_skew.sv
// Diagonal-skew mapping of a latched 2x2 activation matrix onto the two array row inputs.
module operand_skew
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [STEP_W-1:0] i_step,
  input  logic [DATA_W-1:0] i_a00,
  input  logic [DATA_W-1:0] i_a01,
  input  logic [DATA_W-1:0] i_a10,
  input  logic [DATA_W-1:0] i_a11,
  output logic [DATA_W-1:0] o_a_in1_c,
  output logic [DATA_W-1:0] o_a_in2_c
);

  // Row 1 runs one step behind row 0; unused slots are zero-filled.
  always_comb begin
    o_a_in1_c = '0;
    o_a_in2_c = '0;
    unique case (i_step)
      2'd0: o_a_in1_c = i_a00;
      2'd1: begin
        o_a_in1_c = i_a10;
        o_a_in2_c = i_a01;
      end
      2'd2: o_a_in2_c = i_a11;
      default: begin
        o_a_in1_c = '0;
        o_a_in2_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one 2x2 matmul job: weight-load instruction, settle, skewed activation stream, drain, done.
// Defining MATMUL_SEQ_PERF_EN adds saturating job_count / abort_count outputs.
module matmul_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned OPC_W        = 3,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [DATA_W-1:0]        a00,
  input  logic [DATA_W-1:0]        a01,
  input  logic [DATA_W-1:0]        a10,
  input  logic [DATA_W-1:0]        a11,
  output logic [OPC_W+ADDR_W-1:0]  instruction,
  output logic                     valid,
  output logic [DATA_W-1:0]        a_in1,
  output logic [DATA_W-1:0]        a_in2,
  output logic                     busy,
  output logic                     done,
  output logic                     start_ignored
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [31:0]              job_count,
  output logic [15:0]              abort_count
`endif
);

  localparam int unsigned INSTR_W = OPC_W + ADDR_W;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e              r_state, w_state_nxt;
  logic [STEP_W-1:0]   r_step, w_step_nxt;
  logic [DRAIN_W-1:0]  r_drain, w_drain_nxt;
  logic                w_latch, w_abort_acc;

  logic [ADDR_W-1:0]   r_base, w_base_nxt;
  logic [DATA_W-1:0]   r_a00, r_a01, r_a10, r_a11;

  logic [INSTR_W-1:0]  r_instruction, w_instruction_nxt;
  logic                r_valid, w_valid_nxt;
  logic [DATA_W-1:0]   r_a_in1, w_a_in1_nxt;
  logic [DATA_W-1:0]   r_a_in2, w_a_in2_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_start_ignored, w_start_ignored_nxt;
  logic [DATA_W-1:0]   w_skew_a1, w_skew_a2;

  operand_skew #(
    .DATA_W(DATA_W)
  ) u_skew (
    .i_step   (w_step_nxt),
    .i_a00    (r_a00),
    .i_a01    (r_a01),
    .i_a10    (r_a10),
    .i_a11    (r_a11),
    .o_a_in1_c(w_skew_a1),
    .o_a_in2_c(w_skew_a2)
  );

  // Next-state: job progression, with abort overriding every working state.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_drain_nxt = r_drain;
    w_latch     = 1'b0;
    w_abort_acc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_state_nxt = LOAD_W;
          w_latch     = 1'b1;
        end
      end
      LOAD_W: w_state_nxt = SETTLE;
      SETTLE: begin
        w_state_nxt = STREAM;
        w_step_nxt  = '0;
      end
      STREAM: begin
        if (r_step == STEP_W'(STREAM_STEPS - 1)) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = DRAIN_W'(DRAIN_CYCLES - 1);
        end else begin
          w_step_nxt = r_step + STEP_W'(1);
        end
      end
      DRAIN: begin
        if (r_drain == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_drain_nxt = r_drain - DRAIN_W'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort && (r_state inside {LOAD_W, SETTLE, STREAM, DRAIN})) begin
      w_state_nxt = IDLE;
      w_abort_acc = 1'b1;
    end
  end

  // Output decode from the next state so registered outputs line up with the state they describe.
  always_comb begin
    w_base_nxt          = w_latch ? base_addr : r_base;
    w_instruction_nxt   = {OPC_W'(OPC_NOP), ADDR_W'(0)};
    w_valid_nxt         = 1'b0;
    w_a_in1_nxt         = '0;
    w_a_in2_nxt         = '0;
    w_busy_nxt          = w_state_nxt inside {LOAD_W, SETTLE, STREAM, DRAIN};
    w_done_nxt          = (w_state_nxt == DONE);
    w_start_ignored_nxt = start && (r_state != IDLE) && !w_abort_acc;
    if (w_state_nxt == LOAD_W) begin
      w_instruction_nxt = {OPC_W'(OPC_LOAD_W), w_base_nxt};
    end
    if (w_state_nxt == STREAM) begin
      w_valid_nxt = 1'b1;
      w_a_in1_nxt = w_skew_a1;
      w_a_in2_nxt = w_skew_a2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_step          <= '0;
      r_drain         <= '0;
      r_base          <= '0;
      r_a00           <= '0;
      r_a01           <= '0;
      r_a10           <= '0;
      r_a11           <= '0;
      r_instruction   <= '0;
      r_valid         <= 1'b0;
      r_a_in1         <= '0;
      r_a_in2         <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_start_ignored <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_step          <= w_step_nxt;
      r_drain         <= w_drain_nxt;
      r_instruction   <= w_instruction_nxt;
      r_valid         <= w_valid_nxt;
      r_a_in1         <= w_a_in1_nxt;
      r_a_in2         <= w_a_in2_nxt;
      r_busy          <= w_busy_nxt;
      r_done          <= w_done_nxt;
      r_start_ignored <= w_start_ignored_nxt;
      if (w_latch) begin
        r_base <= base_addr;
        r_a00  <= a00;
        r_a01  <= a01;
        r_a10  <= a10;
        r_a11  <= a11;
      end
    end
  end

  assign instruction   = r_instruction;
  assign valid         = r_valid;
  assign a_in1         = r_a_in1;
  assign a_in2         = r_a_in2;
  assign busy          = r_busy;
  assign done          = r_done;
  assign start_ignored = r_start_ignored;

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] r_job_count;
  logic [15:0] r_abort_count;

  // Saturating activity counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_job_count   <= '0;
      r_abort_count <= '0;
    end else begin
      if ((r_state == DONE) && (r_job_count != '1)) begin
        r_job_count <= r_job_count + 32'd1;
      end
      if (w_abort_acc && (r_abort_count != '1)) begin
        r_abort_count <= r_abort_count + 16'd1;
      end
    end
  end

  assign job_count   = r_job_count;
  assign abort_count = r_abort_count;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed self-checking bench for matmul_sequencer; cycle n is the period after the nth edge past start.
module tb_matmul_sequencer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DRAIN  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] a00, a01, a10, a11;
  logic [15:0]       instruction;
  logic              valid;
  logic [DATA_W-1:0] a_in1, a_in2;
  logic              busy, done, start_ignored;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0]       job_count;
  logic [15:0]       abort_count;
`endif

  int checks   = 0;
  int failures = 0;

  matmul_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .base_addr    (base_addr),
    .a00          (a00),
    .a01          (a01),
    .a10          (a10),
    .a11          (a11),
    .instruction  (instruction),
    .valid        (valid),
    .a_in1        (a_in1),
    .a_in2        (a_in2),
    .busy         (busy),
    .done         (done),
    .start_ignored(start_ignored)
`ifdef MATMUL_SEQ_PERF_EN
    ,
    .job_count    (job_count),
    .abort_count  (abort_count)
`endif
  );

  always #5 clk = ~clk;

  logic [51:0] obs;
  assign obs = {instruction, valid, a_in1, a_in2, busy, done, start_ignored};

  // Expected {instruction, valid, a_in1, a_in2, busy, done, start_ignored} in cycle c of a job.
  function automatic logic [51:0] exp_vec(input int c, input logic [12:0] b,
                                          input logic [15:0] m00, input logic [15:0] m01,
                                          input logic [15:0] m10, input logic [15:0] m11);
    logic [15:0] ins = 16'h0;
    logic [15:0] x1  = 16'h0;
    logic [15:0] x2  = 16'h0;
    logic        v   = 1'b0;
    logic        bz  = 1'b0;
    logic        dn  = 1'b0;
    if (c == 1) begin
      ins = {3'b001, b};
      bz  = 1'b1;
    end else if (c == 2) begin
      bz = 1'b1;
    end else if (c >= 3 && c <= 5) begin
      v  = 1'b1;
      bz = 1'b1;
      if (c == 3) x1 = m00;
      else if (c == 4) begin x1 = m10; x2 = m01; end
      else x2 = m11;
    end else if (c >= 6 && c <= 5 + int'(DRAIN)) begin
      bz = 1'b1;
    end else if (c == 6 + int'(DRAIN)) begin
      dn = 1'b1;
    end
    return {ins, v, x1, x2, bz, dn, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a job and lets edge 0 sample it; returns in cycle 1.
  task automatic start_job(input logic [12:0] b, input logic [15:0] m00, input logic [15:0] m01,
                           input logic [15:0] m10, input logic [15:0] m11);
    base_addr = b;
    a00 = m00; a01 = m01; a10 = m10; a11 = m11;
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = 13'h0AAA;
    a00 = 16'hDEAD; a01 = 16'hBEEF; a10 = 16'hCAFE; a11 = 16'hF00D;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; a00 = '0; a01 = '0; a10 = '0; a11 = '0;
    tick();
    checks++;
    if (obs !== 52'h0) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h", obs, 52'h0);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [51:0] e;
    start_job(13'h004, 16'd1, 16'd2, 16'd3, 16'd4);
    checks++;
    if (instruction !== 16'h2004) begin
      failures++;
      $display("FAIL basic_instr: got %h expected %h", instruction, 16'h2004);
    end
    for (int c = 1; c <= 10; c++) begin
      e = exp_vec(c, 13'h004, 16'd1, 16'd2, 16'd3, 16'd4);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL basic cycle %0d: got %h expected %h", c, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    logic [51:0] e;
    start_job(13'h1A5, 16'h0009, 16'h000A, 16'h000B, 16'h000C);
    for (int c = 1; c <= 10; c++) begin
      e = exp_vec(c, 13'h1A5, 16'h0009, 16'h000A, 16'h000B, 16'h000C);
      if (c == 5) e[0] = 1'b1;
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL start_ignored cycle %0d: got %h expected %h", c, obs, e);
      end
      start = (c == 4);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    logic [51:0] e;
    start_job(13'h0F0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    for (int c = 1; c <= 12; c++) begin
      e = (c <= 4) ? exp_vec(c, 13'h0F0, 16'h0011, 16'h0022, 16'h0033, 16'h0044) : 52'h0;
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL abort cycle %0d: got %h expected %h", c, obs, e);
      end
      abort = (c == 4);
      tick();
    end
    abort = 1'b0;
  endtask

  task automatic test_abort_start_idle();
    base_addr = 13'h0123;
    a00 = 16'h1; a01 = 16'h2; a10 = 16'h3; a11 = 16'h4;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (obs !== 52'h0) begin
        failures++;
        $display("FAIL abort_wins_idle cycle %0d: got %h expected %h", c, obs, 52'h0);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [51:0] e;
    start_job(13'h0055, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    tick();
    tick();
    checks++;
    if (obs === 52'h0) begin
      failures++;
      $display("FAIL async_pre_reset: got %h expected nonzero", obs);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 52'h0) begin
      failures++;
      $display("FAIL async_reset_immediate: got %h expected %h", obs, 52'h0);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL async_no_done idle %0d: got %b expected 0", c, done);
      end
      if (c < 3) tick();
      else break;
    end
    start_job(13'h1FFF, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF);
    for (int c = 1; c <= 10; c++) begin
      e = exp_vec(c, 13'h1FFF, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL post_reset_job cycle %0d: got %h expected %h", c, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [51:0] e;
    start_job(13'h004, 16'd1, 16'd2, 16'd3, 16'd4);
    for (int c = 1; c <= 21; c++) begin
      e = (c <= 10) ? exp_vec(c, 13'h004, 16'd1, 16'd2, 16'd3, 16'd4)
                    : exp_vec(c - 10, 13'h008, 16'd5, 16'd6, 16'd7, 16'd8);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs, e);
      end
      if (c == 10) begin
        base_addr = 13'h008;
        a00 = 16'd5; a01 = 16'd6; a10 = 16'd7; a11 = 16'd8;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

`ifdef MATMUL_SEQ_PERF_EN
  task automatic test_perf();
    reset = 1'b0;
    tick();
    checks++;
    if (job_count !== 32'd0 || abort_count !== 16'd0) begin
      failures++;
      $display("FAIL perf_reset: got %0d/%0d expected 0/0", job_count, abort_count);
    end
    reset = 1'b1;
    tick();
    start_job(13'h001, 16'd1, 16'd1, 16'd1, 16'd1);
    repeat (10) tick();
    start_job(13'h002, 16'd2, 16'd2, 16'd2, 16'd2);
    repeat (10) tick();
    start_job(13'h003, 16'd3, 16'd3, 16'd3, 16'd3);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    checks++;
    if (job_count !== 32'd2 || abort_count !== 16'd1) begin
      failures++;
      $display("FAIL perf_counts: got %0d/%0d expected 2/1", job_count, abort_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_abort();
    test_abort_start_idle();
    test_async_reset();
    test_back_to_back();
`ifdef MATMUL_SEQ_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Sequences one 2x2 matrix-multiply job through the TPU top level.
- Per job: issues the weight-load instruction to the control unit, waits one settle cycle, then streams the latched activation matrix into the systolic array with diagonal skew.
- After streaming, waits a fixed drain time for the accumulators to fill, then pulses done.
- Sits between the host/test harness and the top-level instruction, valid and a_in ports.

Parameters:
- DATA_W, 16, activation element width.
- ADDR_W, 13, weight-memory base address width.
- OPC_W, 3, opcode width; DATA_W = OPC_W + ADDR_W is required.
- OPC_LOAD_W, 3'b001, load-weight opcode.
- DRAIN_CYCLES, 3, cycles with valid low after streaming and before done; must be at least 1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  job request; sampled only in IDLE
- abort  in  1  cancel the current job
- base_addr  in  ADDR_W  weight base address; latched on start
- a00, a01, a10, a11  in  DATA_W each  activation matrix A[row][col]; latched on start
- instruction  out  16  {opcode, address} to the control unit
- valid  out  1  activation-valid strobe to the array and accumulators
- a_in1  out  DATA_W  feeds PE(0,0)
- a_in2  out  DATA_W  feeds PE(1,0)
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- start_ignored  out  1  one-cycle pulse: start arrived while not in IDLE

Behaviour:
- All outputs are registered and decoded from the state register.
- Reset (reset=0) immediately forces state IDLE, all outputs 0, and clears latched operands. This holds mid-job; no done is produced for the interrupted job.
- States: IDLE -> LOAD_W -> SETTLE -> STREAM (3 cycles, step counter 0..2) -> DRAIN (DRAIN_CYCLES cycles) -> DONE -> IDLE.
- IDLE: outputs 0. On a clock edge with start=1 and abort=0, latch base_addr and a00..a11, then go to LOAD_W.
- LOAD_W: instruction = {OPC_LOAD_W, base_addr_q}; busy=1; lasts 1 cycle.
- SETTLE: instruction = 0 (NOP); busy=1; lasts 1 cycle, so weights are stable before streaming.
- STREAM: valid=1 and busy=1 on each of the 3 cycles.
  - step0: a_in1=a00, a_in2=0
  - step1: a_in1=a10, a_in2=a01
  - step2: a_in1=0, a_in2=a11
- DRAIN: valid=0, a_in=0, busy=1; down-counter runs DRAIN_CYCLES cycles.
- DONE: done=1, busy=0; lasts 1 cycle, then IDLE.
- Timing: with start sampled at edge 0, LOAD_W occupies cycle 1, STREAM occupies cycles 3-5, and done is high in cycle 6+DRAIN_CYCLES (cycle 9 at the default).
- start=1 in any state other than IDLE: the request is ignored; start_ignored=1 on the next cycle; the running job is unaffected.
- abort=1 in LOAD_W/SETTLE/STREAM/DRAIN: next cycle is IDLE with all outputs 0; no done.
- abort=1 in DONE: done still completes.
- abort and start both high in IDLE: abort wins; nothing is latched.
- Back-to-back jobs: a start in the first IDLE cycle after DONE is accepted, so the minimum spacing between jobs is 7+DRAIN_CYCLES cycles.
- Operands are passed through with no arithmetic; zero fill comes only from the skew pattern.

Optional Feature:
- Macro: MATMUL_SEQ_PERF_EN.
- With the macro defined:
  - adds output ports job_count (32 bits) and abort_count (16 bits); both are 0 at reset.
  - job_count increments on each DONE cycle; abort_count increments on each accepted abort.
  - both counters saturate at their maximum value (no wrap-around).
- Without the macro: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package tpu_pkg holds:
  - the state enum {IDLE, LOAD_W, SETTLE, STREAM, DRAIN, DONE};
  - localparam OPC_NOP=3'b000 and OPC_LOAD_W=3'b001;
  - the STREAM_STEPS=3 constant.
- Sub-module operand_skew (natural split): combinational; maps step index and the latched matrix to a_in1/a_in2 per the pattern above. The top of this block registers its outputs.

Test Plan:
- Basic job: base_addr=13'h004, a00=1, a01=2, a10=3, a11=4, start pulse -> instruction=16'h2004 in cycle 1; valid high in cycles 3-5 with (a_in1,a_in2) = (1,0), (3,2), (0,4); done in cycle 9; busy high in cycles 1-8.
- start pulsed in cycle 4 of a running job -> start_ignored=1 in cycle 5; stream values and done timing unchanged.
- abort in cycle 4 (STREAM) -> cycle 5 is IDLE, valid=0, busy=0; done never asserts.
- reset driven low asynchronously in cycle 3 -> outputs go to 0 immediately; after reset release, a new start runs a full, clean job.
- Back-to-back: second start in cycle 10 with a00..a11=5..8 -> second instruction in cycle 11; second done in cycle 19.
- With MATMUL_SEQ_PERF_EN: run 2 jobs plus 1 aborted job -> job_count=2, abort_count=1.
